sigma_delta_mod: RTL and testbench

SIGMA_DELTA_MOD -- requirements
Module: sigma_delta_mod

---
 rtl/sigma_delta_mod.sv | 129 ++++++++++++
 tb/tb_sigma_delta_mod.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_mod.sv
// Second-order error-feedback sigma-delta DAC modulator with a one-entry
// sample holding register, divided bit clock and per-frame sample loading.
module sigma_delta_mod #(
    parameter int WIDTH   = 16,
    parameter int DR_LOG2 = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             underrun_clr,
    output logic             mclkout,
    output logic             mdata,
    output logic             frame_strobe,
    output logic             underrun
);
    localparam int IW   = WIDTH + 4;
    localparam int SW   = WIDTH + 6;
    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic signed [IW-1:0] I_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] I_MIN = {1'b1, {(IW-1){1'b0}}};
    localparam logic signed [SW-1:0] S_MAX = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};

    logic [DW-1:0]        div_cnt;
    logic                 div_wrap;
    logic                 bit_step;
    logic [DR_LOG2-1:0]   bit_cnt;
    logic [WIDTH-1:0]     hold;
    logic                 hold_full;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     x_eff;
    logic                 accept;
    logic                 frame_load;
    logic                 underrun_set;
    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic signed [IW-1:0] i1_new;
    logic signed [IW-1:0] i2_new;
    logic signed [SW-1:0] fb;
    logic signed [SW-1:0] sum1;
    logic signed [SW-1:0] sum2;

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > S_MAX)
            return I_MAX;
        else if (v < S_MIN)
            return I_MIN;
        else
            return v[IW-1:0];
    endfunction

    assign div_wrap     = (div_cnt == DW'(HALF - 1));
    assign frame_load   = bit_step && (bit_cnt == '0);
    assign frame_strobe = frame_load;
    assign din_ready    = !hold_full;
    assign accept       = din_valid && !hold_full;
    assign underrun_set = frame_load && !hold_full && !accept;

    // An empty holding register at a frame boundary lets a same-cycle sample bypass it.
    always_comb begin
        x_eff = x;
        if (frame_load) begin
            if (hold_full)
                x_eff = hold;
            else if (accept)
                x_eff = din;
        end
    end

    always_comb begin
        fb = '0;
        if (mdata)
            fb[WIDTH] = 1'b1;
        sum1   = $signed({{(SW-IW){i1[IW-1]}}, i1}) + $signed({{(SW-WIDTH){1'b0}}, x_eff}) - fb;
        i1_new = sat(sum1);
        sum2   = $signed({{(SW-IW){i2[IW-1]}}, i2}) + $signed({{(SW-IW){i1_new[IW-1]}}, i1_new}) - fb;
        i2_new = sat(sum2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            mclkout   <= 1'b0;
            bit_step  <= 1'b0;
            bit_cnt   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            x         <= '0;
            i1        <= '0;
            i2        <= '0;
            mdata     <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                mclkout <= ~mclkout;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            // A bit is computed on the edge after each mclkout rise.
            bit_step <= div_wrap && !mclkout;

            if (frame_load) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold      <= din;
            end

            if (bit_step) begin
                x       <= x_eff;
                i1      <= i1_new;
                i2      <= i2_new;
                mdata   <= !i2_new[IW-1] && (i2_new != '0);
                bit_cnt <= bit_cnt + DR_LOG2'(1);
            end

            if (underrun_set)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sigma_delta_mod.sv
// Bench for sigma_delta_mod: randomized and directed scenarios checked against
// a cycle-schedule and integer-arithmetic reference of the modulator.
module tb_sigma_delta_mod;
    localparam int W     = 16;
    localparam int DR    = 8;
    localparam int CD    = 4;
    localparam int FRAME = CD * (1 << DR);
    localparam longint LIM = 64'sd1 << (W + 3);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         underrun_clr = 1'b0;
    logic         mclkout;
    logic         mdata;
    logic         frame_strobe;
    logic         underrun;

    int passed = 0;
    int total  = 0;

    // reference state
    int     cyc;
    int     m_x;
    longint m_i1, m_i2;
    bit     m_md;
    bit     exp_full;
    int     exp_hold;
    bit     exp_underrun;
    int     ones_acc, last_ones, frames;
    bit     new_frame;

    sigma_delta_mod #(.WIDTH(W), .DR_LOG2(DR), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .underrun_clr(underrun_clr), .mclkout(mclkout), .mdata(mdata),
        .frame_strobe(frame_strobe), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic longint sat(input longint v);
        if (v > LIM - 1) return LIM - 1;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    function automatic bit exp_strobe(input int c);
        return (c % FRAME) == CD / 2;
    endfunction

    function automatic bit exp_mclk(input int c);
        return ((c / (CD / 2)) % 2) != 0;
    endfunction

    task automatic model_reset();
        cyc = 0; m_x = 0; m_i1 = 0; m_i2 = 0; m_md = 0;
        exp_full = 0; exp_hold = 0; exp_underrun = 0;
        ones_acc = 0; last_ones = 0; frames = 0; new_frame = 0;
    endtask

    // Advance one clock; the model applies this cycle's inputs, then outputs are sampled 1ns after the edge.
    task automatic step();
        bit strobe_now, step_now, acc, set_ur;
        longint fb;
        strobe_now = exp_strobe(cyc);
        step_now   = (cyc % CD) == CD / 2;
        acc        = din_valid && !exp_full;
        set_ur     = 0;
        new_frame  = strobe_now;
        if (strobe_now) begin
            last_ones = ones_acc; ones_acc = 0; frames++;
            if (exp_full) begin m_x = exp_hold; exp_full = 0; end
            else if (acc) m_x = int'(din);
            else set_ur = 1;
        end else if (acc) begin
            exp_full = 1; exp_hold = int'(din);
        end
        if (set_ur) exp_underrun = 1;
        else if (underrun_clr) exp_underrun = 0;
        if (step_now) begin
            fb = m_md ? (64'sd1 << W) : 64'sd0;
            m_i1 = sat(m_i1 + m_x - fb);
            m_i2 = sat(m_i2 + m_i1 - fb);
            m_md = m_i2 > 0;
        end
        @(posedge clk); #1;
        cyc++;
        if (step_now) ones_acc += int'(mdata);
    endtask

    task automatic do_reset();
        rst = 1'b1; din_valid = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++; if ({mclkout, mdata, frame_strobe, underrun, din_ready} !== 5'b00001)
            $display("FAIL reset_outputs got %b want 00001", {mclkout, mdata, frame_strobe, underrun, din_ready});
        else passed++;
        do_reset();
        total++; if (din_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", din_ready); else passed++;
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            step();
            total++; if (mdata !== 1'b0) $display("FAIL idle_mdata cyc=%0d got %b want 0", cyc, mdata); else passed++;
            total++; if (frame_strobe !== exp_strobe(cyc))
                $display("FAIL idle_strobe cyc=%0d got %b want %b", cyc, frame_strobe, exp_strobe(cyc));
            else passed++;
            total++; if (mclkout !== exp_mclk(cyc))
                $display("FAIL idle_mclk cyc=%0d got %b want %b", cyc, mclkout, exp_mclk(cyc));
            else passed++;
            total++; if (underrun !== (cyc >= CD / 2 + 1))
                $display("FAIL idle_underrun cyc=%0d got %b want %b", cyc, underrun, cyc >= CD / 2 + 1);
            else passed++;
        end
    endtask

    task automatic test_constant(input logic [W-1:0] val, input int lo, input int hi, input string name);
        do_reset();
        din = val; din_valid = 1'b1;
        for (int c = 0; c < 5 * FRAME + 4; c++) begin
            step();
            total++; if (mdata !== logic'(m_md))
                $display("FAIL %s_mdata cyc=%0d got %b want %b", name, cyc, mdata, m_md);
            else passed++;
            total++; if (underrun !== 1'b0) $display("FAIL %s_underrun cyc=%0d got %b want 0", name, cyc, underrun);
            else passed++;
            if (new_frame && frames >= 4) begin
                total++; if (last_ones < lo || last_ones > hi)
                    $display("FAIL %s_density frame=%0d got %0d want %0d..%0d", name, frames - 1, last_ones, lo, hi);
                else passed++;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_bypass();
        do_reset();
        step(); step();
        total++; if (frame_strobe !== 1'b1 || din_ready !== 1'b1)
            $display("FAIL bypass_pre got strobe=%b ready=%b want 1 1", frame_strobe, din_ready);
        else passed++;
        din = 16'h4000; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        total++; if (din_ready !== 1'b1) $display("FAIL bypass_ready got %b want 1", din_ready); else passed++;
        total++; if (underrun !== 1'b0) $display("FAIL bypass_underrun got %b want 0", underrun); else passed++;
        for (int c = 0; c < FRAME; c++) begin
            step();
            total++; if (mdata !== logic'(m_md))
                $display("FAIL bypass_mdata cyc=%0d got %b want %b", cyc, mdata, m_md);
            else passed++;
            total++; if (underrun !== logic'(exp_underrun))
                $display("FAIL bypass_ur cyc=%0d got %b want %b", cyc, underrun, exp_underrun);
            else passed++;
            if (new_frame) begin
                total++; if (last_ones < 62 || last_ones > 66)
                    $display("FAIL bypass_density got %0d want 62..66", last_ones);
                else passed++;
            end
        end
    endtask

    task automatic test_underrun_clr();
        do_reset();
        while (cyc < FRAME + CD / 2) step();
        total++; if (underrun !== 1'b1) $display("FAIL clr_pre got %b want 1", underrun); else passed++;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        total++; if (underrun !== 1'b1) $display("FAIL clr_collide got %b want 1", underrun); else passed++;
        repeat (5) step();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        total++; if (underrun !== 1'b0) $display("FAIL clr_clean got %b want 0", underrun); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4 * FRAME; c++) begin
            din = W'($urandom);
            din_valid = exp_strobe(cyc) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 599) == 0);
            underrun_clr = ($urandom_range(0, 199) == 0);
            step();
            total++; if (mdata !== logic'(m_md))
                $display("FAIL rand_mdata cyc=%0d got %b want %b", cyc, mdata, m_md);
            else passed++;
            total++; if (din_ready !== logic'(!exp_full))
                $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, din_ready, !exp_full);
            else passed++;
            total++; if (underrun !== logic'(exp_underrun))
                $display("FAIL rand_underrun cyc=%0d got %b want %b", cyc, underrun, exp_underrun);
            else passed++;
            total++; if (frame_strobe !== exp_strobe(cyc) || mclkout !== exp_mclk(cyc))
                $display("FAIL rand_timing cyc=%0d got %b%b want %b%b", cyc, frame_strobe, mclkout,
                         exp_strobe(cyc), exp_mclk(cyc));
            else passed++;
        end
        din_valid = 1'b0; underrun_clr = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        din = 16'hC000; din_valid = 1'b1;
        repeat (FRAME + 500) step();
        total++; if (din_ready !== 1'b0) $display("FAIL midrst_full got %b want 0", din_ready); else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++; if ({mclkout, mdata, frame_strobe, underrun, din_ready} !== 5'b00001)
            $display("FAIL midrst_async got %b want 00001", {mclkout, mdata, frame_strobe, underrun, din_ready});
        else passed++;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        for (int c = 0; c < FRAME + 4; c++) begin
            step();
            total++; if (mdata !== 1'b0) $display("FAIL midrst_mdata cyc=%0d got %b want 0", cyc, mdata);
            else passed++;
            total++; if (frame_strobe !== exp_strobe(cyc))
                $display("FAIL midrst_strobe cyc=%0d got %b want %b", cyc, frame_strobe, exp_strobe(cyc));
            else passed++;
            total++; if (underrun !== logic'(exp_underrun))
                $display("FAIL midrst_underrun cyc=%0d got %b want %b", cyc, underrun, exp_underrun);
            else passed++;
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_idle();
        test_constant(16'h8000, 126, 130, "half");
        test_constant(16'hFFFF, 253, 256, "full");
        test_bypass();
        test_underrun_clr();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
